// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store path.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  typedef struct packed {
    logic       is_data;
    logic       we;
    logic       byte_acc;
    logic [1:0] lane;
  } req_t;

  state_t     state, state_nxt;
  req_t       cur;
  logic       grant_dm, grant_if;
  logic       fetch_pri;
  logic [7:0] lane_byte;
  logic       unused_bits;

  // Fetch addresses are word aligned by contract; the low bits carry nothing.
  assign unused_bits = ^{if_addr[1:0], 32'(STARVE_MAX)};

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Never exceeds STARVE_MAX: at that count a pending fetch takes the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n)                  starve_cnt <= '0;
    else if (grant_if)           starve_cnt <= '0;
    else if (grant_dm && if_req) starve_cnt <= starve_cnt + CNT_W'(1);
  end

  assign fetch_pri = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
`else
  assign fetch_pri = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !fetch_pri) begin
          grant_dm  = 1'b1;
          state_nxt = DATA;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH, DATA: if (mem_ready) state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (cur.lane)
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_dm) begin
        cur       <= '{is_data: 1'b1, we: dm_we, byte_acc: dm_byte, lane: dm_addr[1:0]};
        mem_addr  <= {dm_addr[ADDR_W-1:2], 2'b00};
        mem_be    <= dm_byte ? (4'b0001 << dm_addr[1:0]) : 4'b1111;
        mem_wdata <= dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
      end else if (grant_if) begin
        cur      <= '{is_data: 1'b0, we: 1'b0, byte_acc: 1'b0, lane: 2'b00};
        mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
        mem_be   <= 4'b1111;
      end
      if (mem_req && mem_ready) begin
        if (cur.is_data)
          dm_rdata <= cur.byte_acc ? {{(DATA_W-8){1'b0}}, lane_byte} : mem_rdata;
        else
          if_rdata <= mem_rdata;
      end
    end
  end

  // Write enable is qualified so a finished store never leaves mem_we asserted.
  assign mem_req = (state == FETCH) || (state == DATA);
  assign mem_we  = mem_req && cur.we;
  assign if_ack  = (state == RESP) && !cur.is_data;
  assign dm_ack  = (state == RESP) &&  cur.is_data;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-ported unified memory between instruction fetch and the load/store path driven by the decoder's mem_read/mem_write strobes. It runs a request/acknowledge handshake on each side and a held-until-ready handshake toward memory. Data accesses normally win over fetch, with an optional starvation guard. It sits between the fetch stage, the memory stage and the external memory model.

## Interface
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; fixed at 32, 4 byte lanes.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; used only with the guard macro.
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch byte address, word aligned.
- if_rdata  out  DATA_W  fetched word, valid while if_ack is high.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  load/store request, held until dm_ack.
- dm_we  in  1  1 = store (STB/STW/MOV), 0 = load (LBD/LDW).
- dm_byte  in  1  1 = byte access (LBD/STB), 0 = word access.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data; byte stores use bits [7:0].
- dm_rdata  out  DATA_W  load result, valid while dm_ack is high.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid when mem_ready is high.
- mem_ready  in  1  access-complete pulse.

## Operation
- FSM states: IDLE, FETCH, DATA, RESP. Requests are sampled only in IDLE.
- IDLE: if dm_req, go to DATA. Else if if_req, go to FETCH. Else stay. Address, write data, byte enables and we are latched on the transition.
- FETCH/DATA: mem_req = 1, all mem_* outputs stable. On mem_ready, capture read data and go to RESP.
- RESP: assert the matching ack for exactly one cycle, then return to IDLE. Requests in RESP are ignored.
- Requester rule: deassert req at the edge ending its ack cycle unless a new request follows. A req still high in IDLE is treated as a new request.
- Word access:
  - mem_be = 4'b1111.
  - addr[1:0] is ignored; the access is forced aligned.
- Byte store:
  - mem_be = one-hot of addr[1:0] (00 -> 4'b0001).
  - mem_wdata = dm_wdata[7:0] replicated into all four lanes.
- Byte load: dm_rdata = {24'b0, lane selected by addr[1:0]}.
- Fetch: mem_we = 0, mem_be = 4'b1111.
- if_rdata and dm_rdata are registered and hold their value until the next capture.

## Timing
- Reset values:
  - state IDLE.
  - mem_req, mem_we, if_ack, dm_ack = 0.
  - mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - starvation counter = 0.
- Latency:
  - req high in IDLE at edge N -> mem_req high from cycle N+1.
  - mem_ready at edge M -> ack high in cycle M+1.
  - Minimum of 3 cycles from req to ack when mem_ready returns on the first cycle.
- mem_ready arriving in IDLE or RESP is ignored.
- dm_req and if_req high in the same IDLE cycle: data wins, except as the guard below permits.
- Reset asserted mid-access: on that edge mem_req drops, no ack is issued, and the latched request is discarded.
- Back-to-back: the cycle after RESP is IDLE, so the next mem_req rises no earlier than 2 cycles after the previous mem_ready.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each DATA grant made while if_req is high, and clears on any FETCH grant.
  - When the count equals STARVE_MAX and both requests are pending in IDLE, fetch is granted.
- ARB_STARVE_GUARD_EN undefined:
  - Strict data priority; the counter is not built.
  - Fetch can starve indefinitely.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with both reqs high -> all outputs 0, no mem_req. Release -> DATA granted first.
- Fetch only: if_addr = 0x100, mem_rdata = 0xDEADBEEF with mem_ready one cycle after mem_req -> if_ack pulse with if_rdata = 0xDEADBEEF, 3 cycles after req.
- Byte store then byte load at 0x203, dm_wdata = 0x5A:
  - Store -> mem_be = 4'b1000, mem_wdata = 0x5A5A5A5A, mem_addr = 0x200.
  - Load with mem_rdata = 0x5A000000 -> dm_rdata = 0x0000005A.
- Contention: both reqs held continuously, data re-requesting after every ack:
  - Guard undefined -> if_ack never fires.
  - Guard defined with STARVE_MAX = 4 -> four dm_acks, then one if_ack, repeating.
- Reset mid-DATA: assert rst_n = 0 while mem_req is high and mem_ready is low -> mem_req is 0 the next cycle, dm_ack never pulses.
- Ignored ready: pulse mem_ready in IDLE -> no ack, state unchanged.
